// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the 1A2B game sequencer
//
// Contents:
//   game_state_t : 3-bit FSM state, encodings are visible on game_ctrl.state
//   DIGITS       : digits per secret/guess
//   SCORE_W      : width of an A or B score (0..DIGITS)
//   TRIES_W      : width of the try counter
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_GEN   = 3'd2,
    S_READY = 3'd3,
    S_LOAD  = 3'd4,
    S_CHECK = 3'd5,
    S_WIN   = 3'd6,
    S_LOSE  = 3'd7
  } game_state_t;

  localparam int DIGITS  = 4;
  localparam int SCORE_W = $clog2(DIGITS + 1);
  localparam int TRIES_W = 4;

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - controller <-> guess datapath signal bundle
//
// Signals:
//   dp_reset       : clear pulse to the datapath
//   save_test      : secret-generation enable
//   dp_load        : guess-capture strobe
//   dp_valid       : secret complete
//   dp_input_error : current guess has repeated digits
//   dp_same        : guess equals secret
//   Anum / Bnum    : A and B scores of the captured guess
// Modports:
//   master : the game controller
//   slave  : the guess datapath
interface game_dp_if;
  import game_pkg::*;

  logic               dp_reset;
  logic               save_test;
  logic               dp_load;
  logic               dp_valid;
  logic               dp_input_error;
  logic               dp_same;
  logic [SCORE_W-1:0] Anum;
  logic [SCORE_W-1:0] Bnum;

  modport master (
    output dp_reset, save_test, dp_load,
    input  dp_valid, dp_input_error, dp_same, Anum, Bnum
  );

  modport slave (
    input  dp_reset, save_test, dp_load,
    output dp_valid, dp_input_error, dp_same, Anum, Bnum
  );

endinterface

// File: rtl/try_timer.sv
// rtl/try_timer.sv - idle counter for the READY state with clear and expiry
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   run_i    : count while high; counter is held at 0 while low
//   clr_i    : restart the count from 0
//   expire_o : high in the cycle the count reaches CYCLES-1 while running
// The counter returns to 0 after an expiry so the next window is a full one.
module try_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  assign expire_o = run_i && (count_q == CW'(CYCLES - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (!run_i || clr_i || expire_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencer for the 1A2B number-guessing datapath
//
// Optional feature macro: GAME_CTRL_TIMEOUT_EN (READY idle timeout costs a try)
//
// Ports:
//   clka, reset          : clock and synchronous active-high reset
//   start                : pulse, begin a new game from IDLE/WIN/LOSE
//   guess_submit         : pulse, guess present on datapath inputs
//   dp (master)          : datapath strobes out, status and scores in
//   state                : current FSM state encoding
//   tries                : guesses consumed this game
//   last_A, last_B       : scores of the last checked guess
//   result_valid         : pulse when last_A/last_B update
//   err_pulse            : pulse when a guess is rejected
//   win, lose            : levels while in WIN / LOSE
//   timeout_pulse        : pulse when a READY timeout expires
module game_ctrl
  import game_pkg::*;
#(
  parameter int MAX_TRIES      = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               start,
  input  logic               guess_submit,
  game_dp_if.master          dp,
  output logic [2:0]         state,
  output logic [TRIES_W-1:0] tries,
  output logic [SCORE_W-1:0] last_A,
  output logic [SCORE_W-1:0] last_B,
  output logic               result_valid,
  output logic               err_pulse,
  output logic               win,
  output logic               lose,
  output logic               timeout_pulse
);

  game_state_t        state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [SCORE_W-1:0] last_a_q, last_a_d;
  logic [SCORE_W-1:0] last_b_q, last_b_d;
  logic               result_q, result_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;

  logic               timeout_take;
  logic [TRIES_W-1:0] tries_inc;
  logic               last_try;

  // Increment that never wraps past MAX_TRIES.
  assign tries_inc = (tries_q >= TRIES_W'(MAX_TRIES)) ? tries_q : tries_q + TRIES_W'(1);
  // True when the try being consumed now is the final one allowed.
  assign last_try  = ({1'b0, tries_q} + 5'd1) == 5'(MAX_TRIES);

`ifdef GAME_CTRL_TIMEOUT_EN
  logic tmr_expire;

  try_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_try_timer (
    .clk_i    (clka),
    .rst_i    (reset),
    .run_i    (state_q == S_READY),
    .clr_i    (guess_submit),
    .expire_o (tmr_expire)
  );

  // A submit on the expiry cycle takes precedence over the timeout.
  assign timeout_take = tmr_expire && !guess_submit;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign timeout_take       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    last_a_d = last_a_q;
    last_b_d = last_b_q;
    result_d = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        tries_d  = '0;
        last_a_d = '0;
        last_b_d = '0;
        state_d  = S_GEN;
      end
      S_GEN: begin
        if (dp.dp_valid) state_d = S_READY;
      end
      S_READY: begin
        if (guess_submit) begin
          if (dp.dp_input_error) err_d = 1'b1;
          else                   state_d = S_LOAD;
        end else if (timeout_take) begin
          tmo_d    = 1'b1;
          tries_d  = tries_inc;
          last_a_d = '0;
          last_b_d = '0;
          if (last_try) state_d = S_LOSE;
        end
      end
      S_LOAD: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        last_a_d = dp.Anum;
        last_b_d = dp.Bnum;
        tries_d  = tries_inc;
        result_d = 1'b1;
        if (dp.dp_same)     state_d = S_WIN;
        else if (last_try)  state_d = S_LOSE;
        else                state_d = S_READY;
      end
      S_WIN, S_LOSE: begin
        if (start) state_d = S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tries_q  <= '0;
      last_a_q <= '0;
      last_b_q <= '0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      last_a_q <= last_a_d;
      last_b_q <= last_b_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Datapath strobes are pure state decodes so each lasts exactly one state.
  assign dp.dp_reset  = (state_q == S_CLR);
  assign dp.save_test = (state_q == S_GEN);
  assign dp.dp_load   = (state_q == S_LOAD);

  assign state         = state_q;
  assign tries         = tries_q;
  assign last_A        = last_a_q;
  assign last_B        = last_b_q;
  assign result_valid  = result_q;
  assign err_pulse     = err_q;
  assign win           = (state_q == S_WIN);
  assign lose          = (state_q == S_LOSE);
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;
  import game_pkg::*;

  logic         clka = 1'b0;
  logic         reset;
  logic         start;
  logic         guess_submit;
  logic [2:0]   state;
  logic [3:0]   tries;
  logic [2:0]   last_A;
  logic [2:0]   last_B;
  logic         result_valid;
  logic         err_pulse;
  logic         win;
  logic         lose;
  logic         timeout_pulse;

  int checks   = 0;
  int failures = 0;

  game_dp_if dp ();

  game_ctrl #(
    .MAX_TRIES      (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clka          (clka),
    .reset         (reset),
    .start         (start),
    .guess_submit  (guess_submit),
    .dp            (dp),
    .state         (state),
    .tries         (tries),
    .last_A        (last_A),
    .last_B        (last_B),
    .result_valid  (result_valid),
    .err_pulse     (err_pulse),
    .win           (win),
    .lose          (lose),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({dp.dp_reset, dp.save_test, dp.dp_load, tries, last_A, last_B,
                result_valid, err_pulse, win, lose, timeout_pulse});
  endfunction

  // Start a game from IDLE/WIN/LOSE and walk it to READY.
  task automatic to_ready();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_state", 32'(state), 32'd1);
    chk("clr_dp_reset", 32'(dp.dp_reset), 32'd1);
    tick();
    chk("gen_state", 32'(state), 32'd2);
    chk("gen_dp_reset_low", 32'(dp.dp_reset), 32'd0);
    chk("gen_tries_clr", 32'({tries, last_A, last_B}), 32'd0);
    dp.dp_valid = 1'b1;
    tick();
    dp.dp_valid = 1'b0;
    chk("ready_state", 32'(state), 32'd3);
    chk("ready_save_low", 32'(dp.save_test), 32'd0);
  endtask

  // One accepted guess from READY through CHECK.
  task automatic guess(input logic [2:0] a, input logic [2:0] b, input logic same,
                       input logic [2:0] exp_state, input logic [3:0] exp_tries);
    dp.Anum           = a;
    dp.Bnum           = b;
    dp.dp_same        = same;
    dp.dp_input_error = 1'b0;
    guess_submit      = 1'b1;
    tick();
    guess_submit = 1'b0;
    chk("load_state", 32'(state), 32'd4);
    chk("load_strobe", 32'(dp.dp_load), 32'd1);
    tick();
    chk("check_state", 32'(state), 32'd5);
    chk("check_no_result", 32'({dp.dp_load, result_valid}), 32'd0);
    tick();
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("last_ab", 32'({last_A, last_B}), 32'({a, b}));
    chk("tries", 32'(tries), 32'(exp_tries));
    chk("post_state", 32'(state), 32'(exp_state));
    dp.dp_same = 1'b0;
  endtask

  initial begin
    int save_hi;
    int tmo_seen;

    reset             = 1'b1;
    start             = 1'b0;
    guess_submit      = 1'b0;
    dp.dp_valid       = 1'b0;
    dp.dp_input_error = 1'b0;
    dp.dp_same        = 1'b0;
    dp.Anum           = 3'd0;
    dp.Bnum           = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", all_outs(), 32'd0);

    // Start, then hold GEN for several cycles before dp_valid.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clr", 32'(state), 32'd1);
    chk("start_dp_reset", 32'(dp.dp_reset), 32'd1);
    save_hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dp.save_test && state == 3'd2 && !dp.dp_reset) save_hi++;
    end
    chk("gen_save_held", 32'(save_hi), 32'd6);
    dp.dp_valid = 1'b1;
    tick();
    dp.dp_valid = 1'b0;
    chk("gen_to_ready", 32'(state), 32'd3);
    chk("save_dropped", 32'(dp.save_test), 32'd0);

    // start is ignored in READY.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", 32'(state), 32'd3);

    // Rejected guess.
    dp.dp_input_error = 1'b1;
    guess_submit      = 1'b1;
    tick();
    guess_submit      = 1'b0;
    dp.dp_input_error = 1'b0;
    chk("err_pulse", 32'(err_pulse), 32'd1);
    chk("err_state", 32'(state), 32'd3);
    chk("err_tries", 32'(tries), 32'd0);
    chk("err_no_load", 32'(dp.dp_load), 32'd0);
    tick();
    chk("err_one_cycle", 32'(err_pulse), 32'd0);

    // Three misses with MAX_TRIES=3; back-to-back submits.
    guess(3'd1, 3'd2, 1'b0, 3'd3, 4'd1);
    guess(3'd0, 3'd3, 1'b0, 3'd3, 4'd2);
    guess(3'd2, 3'd1, 1'b0, 3'd7, 4'd3);
    chk("lose_level", 32'({win, lose}), 32'd1);
    guess_submit = 1'b1;
    tick();
    guess_submit = 1'b0;
    chk("lose_frozen", 32'({state, tries, last_A, last_B, dp.dp_load, result_valid}),
        32'({3'd7, 4'd3, 3'd2, 3'd1, 1'b0, 1'b0}));

    // Win on the final try beats exhaustion.
    to_ready();
    guess(3'd1, 3'd1, 1'b0, 3'd3, 4'd1);
    guess(3'd0, 3'd2, 1'b0, 3'd3, 4'd2);
    guess(3'd4, 3'd0, 1'b1, 3'd6, 4'd3);
    chk("win_level", 32'({win, lose}), 32'd2);
    tick();
    chk("win_held", 32'({state, win, result_valid}), 32'({3'd6, 1'b1, 1'b0}));

    // Reset while in LOAD.
    to_ready();
    dp.Anum      = 3'd3;
    guess_submit = 1'b1;
    tick();
    guess_submit = 1'b0;
    chk("pre_reset_load", 32'(state), 32'd4);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("load_reset_state", 32'(state), 32'd0);
    chk("load_reset_outs", all_outs(), 32'd0);

    // READY idle behaviour: timeout if built, otherwise nothing happens.
    tick();
    to_ready();
    tmo_seen = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (timeout_pulse) tmo_seen++;
    end
    chk("no_early_timeout", 32'(tmo_seen), 32'd0);
    tick();
`ifdef GAME_CTRL_TIMEOUT_EN
    chk("timeout_pulse", 32'(timeout_pulse), 32'd1);
    chk("timeout_tries", 32'(tries), 32'd1);
    chk("timeout_state", 32'({state, result_valid}), 32'({3'd3, 1'b0}));
    tick();
    chk("timeout_one_cycle", 32'(timeout_pulse), 32'd0);
`else
    chk("timeout_tied_low", 32'(timeout_pulse), 32'd0);
    chk("idle_tries", 32'({state, tries}), 32'({3'd3, 4'd0}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game sequencer for the 1A2B number-guessing design. It drives the guess datapath through each game: clear, generate the secret, accept and vet player guesses, capture A/B scores, count tries, and declare win or lose. It sits between the player-input and display logic and the datapath, on the datapath's `clka` domain.

## Interface
Parameters:
- `MAX_TRIES`, default 10: guesses allowed per game. Legal range 1..15.
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed in READY. Used only with `GAME_CTRL_TIMEOUT_EN`. Minimum 2.

Ports:
- `clka` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that starts a new game.
- `guess_submit` in 1: one-cycle pulse; the player's guess is on the datapath inputs this cycle.
- `dp_valid` in 1: datapath reports the secret is complete.
- `dp_input_error` in 1: datapath reports the current guess has repeated digits.
- `dp_same` in 1: datapath reports the guess equals the secret.
- `Anum` in 3: datapath A score, 0..4.
- `Bnum` in 3: datapath B score, 0..4.
- `dp_reset` out 1: one-cycle clear pulse to the datapath.
- `save_test` out 1: secret-generation enable to the datapath.
- `dp_load` out 1: one-cycle guess-capture strobe to the datapath.
- `state` out 3: current FSM state encoding.
- `tries` out 4: guesses consumed this game.
- `last_A` out 3: registered A score of the last checked guess.
- `last_B` out 3: registered B score of the last checked guess.
- `result_valid` out 1: one-cycle pulse when `last_A`/`last_B` update.
- `err_pulse` out 1: one-cycle pulse when a guess is rejected.
- `win` out 1: level; high while in WIN.
- `lose` out 1: level; high while in LOSE.
- `timeout_pulse` out 1: one-cycle pulse when a READY timeout expires.

## Operation
FSM states and encoding:
- IDLE=0: all strobes 0. `start` → CLR.
- CLR=1: `dp_reset`=1 for exactly one cycle; `tries`, `last_A`, `last_B` clear to 0. Next state GEN.
- GEN=2: `save_test`=1 every cycle in GEN. When `dp_valid` is sampled 1 → READY, and `save_test` drops on that edge.
- READY=3: waits for `guess_submit`.
  - `guess_submit` with `dp_input_error`=1: `err_pulse` next cycle, stay in READY, `tries` unchanged.
  - `guess_submit` with `dp_input_error`=0: `dp_load`=1 for one cycle → LOAD.
- LOAD=4: one settle cycle for datapath capture. Next state CHECK.
- CHECK=5:
  - Register `last_A`←`Anum`, `last_B`←`Bnum`; `tries`←`tries`+1; pulse `result_valid`.
  - If `dp_same` → WIN. Priority: win beats try exhaustion on the final try.
  - Else if `tries`+1 == `MAX_TRIES` → LOSE.
  - Else → READY.
- WIN=6 / LOSE=7: `win`/`lose` held high; `tries`, `last_A`, `last_B` frozen. `start` → CLR.

Rules:
- `start` is ignored in CLR, GEN, READY, LOAD and CHECK.
- `guess_submit` is ignored outside READY.
- `tries` saturates at `MAX_TRIES` and never wraps.
- `reset` at any state: next edge forces IDLE and all outputs to 0, regardless of other inputs.

## Timing
- Reset value of every output is 0; `state` resets to IDLE (0).
- `start` at edge N: CLR at N+1, `dp_reset` high during N+1, GEN at N+2.
- GEN to READY latency is datapath-determined (at least 5 cycles). The controller waits indefinitely in GEN.
- `guess_submit` accepted at edge N: `dp_load` high during N+1 (LOAD), CHECK at N+2. `result_valid`, `last_A`/`last_B`, `tries` update at edge N+3; `win`/`lose` rise at N+3.
- Reject path: `err_pulse` high for the one cycle after the sampled submit.
- Back-to-back submits: the earliest next accepted submit is the first cycle back in READY.

## Configuration
- `GAME_CTRL_TIMEOUT_EN` defined:
  - A cycle counter runs in READY and clears on entry to READY and on any `guess_submit`.
  - When it reaches `TIMEOUT_CYCLES`-1: pulse `timeout_pulse`, set `tries`←`tries`+1, `last_A`=`last_B`=0, no `result_valid`.
  - Then → LOSE if `tries`+1 == `MAX_TRIES`, else stay in READY with the counter cleared.
  - `guess_submit` on the expiry cycle wins; no timeout is taken that cycle.
- `GAME_CTRL_TIMEOUT_EN` undefined: no counter is built; `timeout_pulse` is tied to 0; `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `game_pkg`: state enum `game_state_t` (3-bit, encodings above), `DIGITS`=4, score width 3, tries width 4.
- One sub-module is natural: `try_timer` (timeout counter with clear/expire), instantiated only under `GAME_CTRL_TIMEOUT_EN`.

## Test plan
- Reset then `start`: `dp_reset` high exactly 1 cycle, `save_test` high until `dp_valid`; `state` sequence 0→1→2→3.
- In READY, submit with `dp_input_error`=1: one `err_pulse`, `tries` stays 0, `state` stays 3.
- Submit with `Anum`=1, `Bnum`=2, `dp_same`=0: `result_valid` at submit+3, `last_A`=1, `last_B`=2, `tries`=1, back to READY.
- `MAX_TRIES`=3, three non-matching guesses: `lose`=1 after the 3rd CHECK, `tries`=3. `dp_same`=1 on the 3rd guess instead gives `win`=1.
- `reset` asserted in LOAD: next cycle `state`=0, all outputs 0. `start` in READY is ignored.
- With `GAME_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no submit: `timeout_pulse` 8 cycles after READY entry, `tries`=1.
